// File: rtl/mux4_scan_ctrl.sv
// mux4_scan_ctrl: scan controller for a 4-to-1 mux.
// Steps Sel through 0..3, holds each value for DWELL cycles and samples Z at
// the last edge of each window. The four samples form a frame that is offered
// downstream on a valid/ready handshake. Supports single-shot and continuous
// scanning.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           begin a scan (honoured only when idle)
//   mode            0 = single scan, 1 = continuous (read at each completion)
//   Z               mux output being scanned
//   Sel             mux select
//   Frame           packed samples, bit i = Z sampled while Sel == i
//   Valid, Ready    downstream handshake for Frame
//   Busy            scan in progress
//   Overrun         sticky: a completed frame was dropped
module mux4_scan_ctrl #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned CW    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mode,
  input  logic       Z,
  output logic [1:0] Sel,
  output logic [3:0] Frame,
  output logic       Valid,
  input  logic       Ready,
  output logic       Busy,
  output logic       Overrun
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DWELL = 1'b1
  } state_t;

  localparam logic [CW-1:0] RELOAD = CW'(DWELL - 1);

  state_t          state_q, state_n;
  logic [1:0]      ch_q, ch_n;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic [2:0]      shadow_q, shadow_n;
  logic [3:0]      frame_q, frame_n;
  logic            valid_q, valid_n;
  logic            busy_q, busy_n;
  logic            overrun_q, overrun_n;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ch_q      <= 2'd0;
      cnt_q     <= '0;
      shadow_q  <= 3'd0;
      frame_q   <= 4'd0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      ch_q      <= ch_n;
      cnt_q     <= cnt_n;
      shadow_q  <= shadow_n;
      frame_q   <= frame_n;
      valid_q   <= valid_n;
      busy_q    <= busy_n;
      overrun_q <= overrun_n;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_n   = state_q;
    ch_n      = ch_q;
    cnt_n     = cnt_q;
    shadow_n  = shadow_q;
    frame_n   = frame_q;
    valid_n   = valid_q;
    overrun_n = overrun_q;

    // Consumption; a frame load below on the same edge re-asserts Valid
    if (valid_q && Ready) valid_n = 1'b0;

    case (state_q)
      S_IDLE: begin
        ch_n  = 2'd0;
        cnt_n = '0;
        if (start) begin
          state_n   = S_DWELL;
          cnt_n     = RELOAD;
          overrun_n = 1'b0;
        end
      end

      S_DWELL: begin
        if (cnt_q != '0) begin
          cnt_n = cnt_q - CW'(1);
        end else begin
          cnt_n = RELOAD;
          if (ch_q != 2'd3) begin
            shadow_n[ch_q] = Z;
            ch_n           = ch_q + 2'd1;
          end else begin
            // Scan completion: load unless an unconsumed frame would be lost
            if (!valid_q || Ready) begin
              frame_n = {Z, shadow_q};
              valid_n = 1'b1;
            end else begin
              overrun_n = 1'b1;
            end
            ch_n = 2'd0;
            if (!mode) begin
              state_n = S_IDLE;
              cnt_n   = '0;
            end
          end
        end
      end

      default: state_n = S_IDLE;
    endcase

    busy_n = (state_n == S_DWELL);
  end

  // Sel comes straight from the channel register, so it never glitches
  assign Sel     = ch_q;
  assign Frame   = frame_q;
  assign Valid   = valid_q;
  assign Busy    = busy_q;
  assign Overrun = overrun_q;

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Bench for mux4_scan_ctrl: DWELL=4 instance for the main scans and a
// DWELL=1 instance for the single-cycle-window case. A behavioural 4:1 mux
// closes the loop from Sel back to Z.
module tb_mux4_scan_ctrl;

  logic clk = 1'b0;
  logic rst;

  logic       start, mode, ready, z;
  logic [1:0] sel;
  logic [3:0] frame, abcd;
  logic       valid, busy, overrun;

  logic       start1, mode1, ready1, z1;
  logic [1:0] sel1;
  logic [3:0] frame1, abcd1;
  logic       valid1, busy1, overrun1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Mux model: abcd bit i is the input selected by Sel == i
  assign z  = abcd[sel];
  assign z1 = abcd1[sel1];

  mux4_scan_ctrl #(.DWELL(4), .CW(8)) dut4 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .Z(z), .Sel(sel),
    .Frame(frame), .Valid(valid), .Ready(ready), .Busy(busy), .Overrun(overrun)
  );

  mux4_scan_ctrl #(.DWELL(1), .CW(8)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .mode(mode1), .Z(z1), .Sel(sel1),
    .Frame(frame1), .Valid(valid1), .Ready(ready1), .Busy(busy1), .Overrun(overrun1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pulse start on dut4; returns at the negedge just after the start edge (k=0)
  task automatic start_pulse();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // From negedge k0 to negedge k1, check Sel holds each value for 4 cycles
  task automatic track(input int k0, input int k1);
    for (int k = k0; k < k1; k++) begin
      chk($sformatf("sel_k%0d", k), 32'(sel), 32'((k / 4) % 4));
      chk($sformatf("busy_k%0d", k), 32'(busy), 32'd1);
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [3:0] abcd;
    logic [3:0] frame;
  } vec_t;

  vec_t vecs[5];

  initial begin
    // {D C B A} input levels and the frame they must produce
    vecs[0] = '{abcd: 4'b1101, frame: 4'b1101};
    vecs[1] = '{abcd: 4'b0010, frame: 4'b0010};
    vecs[2] = '{abcd: 4'b0000, frame: 4'b0000};
    vecs[3] = '{abcd: 4'b1111, frame: 4'b1111};
    vecs[4] = '{abcd: 4'b1000, frame: 4'b1000};

    rst = 1'b1;
    start = 1'b0; mode = 1'b0; ready = 1'b0; abcd = 4'b0000;
    start1 = 1'b0; mode1 = 1'b0; ready1 = 1'b0; abcd1 = 4'b0000;
    repeat (2) @(negedge clk);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_frame", 32'(frame), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst1_sel", 32'(sel1), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single scans with a consume afterwards
    for (int i = 0; i < 5; i++) begin
      abcd = vecs[i].abcd; mode = 1'b0; ready = 1'b0;
      start_pulse();
      chk($sformatf("v%0d_valid_start", i), 32'(valid), 32'd0);
      track(0, 15);
      chk($sformatf("v%0d_valid_k15", i), 32'(valid), 32'd0);
      track(15, 16);
      chk($sformatf("v%0d_valid", i), 32'(valid), 32'd1);
      chk($sformatf("v%0d_frame", i), 32'(frame), 32'(vecs[i].frame));
      chk($sformatf("v%0d_busy_end", i), 32'(busy), 32'd0);
      chk($sformatf("v%0d_sel_end", i), 32'(sel), 32'd0);
      chk($sformatf("v%0d_overrun", i), 32'(overrun), 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d_valid_hold", i), 32'(valid), 32'd1);
      ready = 1'b1;
      @(negedge clk) ready = 1'b0;
      chk($sformatf("v%0d_valid_consumed", i), 32'(valid), 32'd0);
      chk($sformatf("v%0d_frame_held", i), 32'(frame), 32'(vecs[i].frame));
    end

    // Continuous, no consumer: second frame dropped, Overrun set
    abcd = 4'b1101; mode = 1'b1; ready = 1'b0;
    start_pulse();
    track(0, 16);
    chk("cont_valid1", 32'(valid), 32'd1);
    chk("cont_frame1", 32'(frame), 32'hd);
    chk("cont_busy1", 32'(busy), 32'd1);
    abcd = 4'b0010;
    track(16, 32);
    chk("cont_frame2_dropped", 32'(frame), 32'hd);
    chk("cont_overrun", 32'(overrun), 32'd1);
    chk("cont_busy2", 32'(busy), 32'd1);
    chk("cont_valid2", 32'(valid), 32'd1);
    mode = 1'b0;
    track(32, 48);
    chk("cont_stop_busy", 32'(busy), 32'd0);
    chk("cont_stop_overrun", 32'(overrun), 32'd1);
    chk("cont_stop_frame", 32'(frame), 32'hd);
    ready = 1'b1;
    @(negedge clk) ready = 1'b0;
    chk("cont_stop_consumed", 32'(valid), 32'd0);

    // Continuous, Ready exactly on the completion edge: reload, Valid stays
    abcd = 4'b1101; mode = 1'b1; ready = 1'b0;
    start_pulse();
    chk("ovr_cleared_by_start", 32'(overrun), 32'd0);
    track(0, 16);
    chk("same_edge_valid1", 32'(valid), 32'd1);
    chk("same_edge_frame1", 32'(frame), 32'hd);
    abcd = 4'b0010;
    track(16, 31);
    ready = 1'b1;
    @(negedge clk) ready = 1'b0;
    chk("same_edge_valid2", 32'(valid), 32'd1);
    chk("same_edge_frame2", 32'(frame), 32'h2);
    chk("same_edge_overrun", 32'(overrun), 32'd0);
    chk("same_edge_busy", 32'(busy), 32'd1);

    // Asynchronous reset in the middle of the Sel=2 window
    track(32, 41);
    chk("pre_rst_sel", 32'(sel), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("arst_sel", 32'(sel), 32'd0);
    chk("arst_frame", 32'(frame), 32'd0);
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_overrun", 32'(overrun), 32'd0);
    @(negedge clk) rst = 1'b0;
    abcd = 4'b0110; mode = 1'b0;
    start_pulse();
    track(0, 15);
    chk("post_rst_valid_k15", 32'(valid), 32'd0);
    track(15, 16);
    chk("post_rst_valid", 32'(valid), 32'd1);
    chk("post_rst_frame", 32'(frame), 32'h6);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // DWELL=1: one cycle per Sel value, extra start ignored
    abcd1 = 4'b1011;
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    chk("d1_sel_k0", 32'(sel1), 32'd0);
    chk("d1_busy_k0", 32'(busy1), 32'd1);
    @(negedge clk);
    chk("d1_sel_k1", 32'(sel1), 32'd1);
    start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    chk("d1_sel_k2", 32'(sel1), 32'd2);
    @(negedge clk);
    chk("d1_sel_k3", 32'(sel1), 32'd3);
    chk("d1_valid_k3", 32'(valid1), 32'd0);
    chk("d1_busy_k3", 32'(busy1), 32'd1);
    @(negedge clk);
    chk("d1_valid_k4", 32'(valid1), 32'd1);
    chk("d1_frame_k4", 32'(frame1), 32'hb);
    chk("d1_busy_k4", 32'(busy1), 32'd0);
    chk("d1_sel_k4", 32'(sel1), 32'd0);
    @(negedge clk);
    chk("d1_stays_idle", 32'(busy1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
